r_forward_arbiter: RTL and testbench
====================================

# r_forward_arbiter

Round-robin arbiter sharing one downstream read-address forward channel (77-bit DATA/VALID/READY, address in DATA[68:33]) between N upstream requesters. It sits upstream of the per-slave forward filters: each master's forward channel enters here, one winner at a time is forwarded, and the winning port index is logged in an in-order FIFO. The read-response router uses that FIFO to steer returning data back to the right master.

## Interface
- N_PORTS, default 4: number of requesters; legal range 2..8.
- ORDER_DEPTH, default 8: depth of the grant-order FIFO (power of 2, ≥2).
- ID_W, default clog2(N_PORTS): width of the port index.
- CLK  in  1: single clock; all state updates on its rising edge.
- RST  in  1: reset, synchronous and active-high.
- DATAi  in  N_PORTS*77: requester payloads; port k occupies bits [77k+76:77k].
- VALIDi  in  N_PORTS: per-requester valid.
- READYi  out  N_PORTS: per-requester ready; at most one bit high.
- DATAo  out  77: forwarded payload.
- VALIDo  out  1: forwarded valid.
- READYo  in  1: downstream ready.
- ORDER_ID  out  ID_W: port index at the FIFO head.
- ORDER_VALID  out  1: FIFO not empty.
- ORDER_POP  in  1: response router consumed the head entry; ignored when ORDER_VALID=0.

## Operation
- States: IDLE, BUSY. Registers:
  - state;
  - grant index `gnt` (ID_W);
  - round-robin pointer `rr` (ID_W), meaning the highest-priority port;
  - order FIFO with count.
- IDLE:
  - If any VALIDi is set and the FIFO is not full, select the first set VALIDi bit scanning from `rr` upward with wrap-around.
  - Load `gnt`, set `rr` = (gnt+1) mod N_PORTS, go to BUSY.
  - Otherwise stay in IDLE. `rr` is unchanged.
- BUSY:
  - VALIDo = VALIDi[gnt]; DATAo = DATAi slice gnt; READYi[gnt] = READYo; all other READYi = 0.
  - On VALIDo & READYo: push `gnt` into the FIFO and go to IDLE.
- Outside BUSY: VALIDo=0, DATAo=0, READYi=0.
- The grant is held until handshake; a requester never loses its grant after VALIDo rises.
- The FIFO is checked only at grant time. Pops never fill it, so a push from BUSY always has space and no overflow path exists.
- Simultaneous push and pop in one cycle: count unchanged, head advances, new entry written.
- ORDER_POP with the FIFO empty: no effect. Count never underflows.
- Requester dropping VALIDi while granted (protocol violation): VALIDo follows it combinationally. The grant stays held, no push occurs.
- The payload is not inspected or modified. Address decoding stays in the downstream filters.

## Timing
- RST=1 at a rising edge:
  - state=IDLE, gnt=0, rr=0, FIFO emptied;
  - next cycle READYi=0, VALIDo=0, DATAo=0, ORDER_VALID=0, ORDER_ID=0.
- Reset applies mid-transfer: a pending BUSY grant is abandoned without a push.
- Latency: VALIDi at edge t (IDLE, FIFO not full) gives VALIDo high from cycle t+1. The handshake may occur in that same cycle.
- Peak throughput: one transfer per 2 cycles (BUSY→IDLE→BUSY).
- VALIDo/DATAo/READYi are combinational from state and gnt plus current VALIDi/DATAi/READYo. There is no register on the datapath.
- ORDER_VALID/ORDER_ID are registered and update the cycle after a push or pop. A push-to-empty FIFO shows ORDER_VALID one cycle after the handshake.

## Structure
- Shared package holds:
  - DATA_W=77, ADDR_MSB=68, ADDR_LSB=33;
  - clog2 function;
  - state encoding (IDLE=0, BUSY=1).
- These constants are shared with the forward filters and the response router.
- Sub-module r_order_fifo (synchronous FIFO, width ID_W, depth ORDER_DEPTH, registered head/valid, full/empty flags).
- The arbiter FSM and mux stay in the top module.

## Test plan
- Single requester: VALIDi=4'b0100, DATAi[2] carries address 36'h0_1000_0000, READYo=1. Expect VALIDo high one cycle after VALIDi, DATAo equals the port-2 slice, READYi=4'b0100 for one cycle. ORDER_ID=2 and ORDER_VALID=1 the cycle after handshake.
- All four requesters held valid, READYo=1, no pops, ORDER_DEPTH=8. Expect grant order 0,1,2,3,0,1,2,3, one grant every 2 cycles. After 8 grants the FIFO is full: VALIDo stays 0 until a pop. After one ORDER_POP the next grant is port 0, and ORDER_ID sequence on pops is 0,1,2,3,...
- Backpressure: grant port 1, hold READYo=0 for 5 cycles while port 3 is also valid. Expect VALIDo=1, READYi=4'b0000, DATAo stable, gnt still 1. READYo=1 then gives handshake on port 1, and port 3 is granted next.
- Simultaneous push and pop with FIFO count=3. Expect count remains 3, and the head advances to the second entry.
- RST asserted while BUSY with READYo=0. Expect the next cycle VALIDo=0, READYi=0, ORDER_VALID=0. After release, VALIDi=4'b0010 is granted to port 1 (rr restarted at 0).

Source files
------------

// File: rtl/r_forward_arbiter_pkg.sv
// r_forward_arbiter_pkg: shared forward-channel constants, state encoding and clog2 helper
package r_forward_arbiter_pkg;
  localparam int DATA_W = 77;
  localparam int ADDR_MSB = 68;
  localparam int ADDR_LSB = 33;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/r_forward_arbiter_if.sv
// r_forward_arbiter_if: upstream requesters, downstream forward channel and grant-order port
interface r_forward_arbiter_if
  import r_forward_arbiter_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int ID_W = clog2(N_PORTS)
);
  logic [N_PORTS*DATA_W-1:0] DATAi;
  logic [N_PORTS-1:0] VALIDi;
  logic [N_PORTS-1:0] READYi;
  logic [DATA_W-1:0] DATAo;
  logic VALIDo;
  logic READYo;
  logic [ID_W-1:0] ORDER_ID;
  logic ORDER_VALID;
  logic ORDER_POP;
  modport master (
    output DATAi, VALIDi, READYo, ORDER_POP,
    input READYi, DATAo, VALIDo, ORDER_ID, ORDER_VALID
  );
  modport slave (
    input DATAi, VALIDi, READYo, ORDER_POP,
    output READYi, DATAo, VALIDo, ORDER_ID, ORDER_VALID
  );
endinterface

// File: rtl/r_forward_arbiter_order_fifo.sv
// r_order_fifo: in-order grant log with registered head/valid
module r_order_fifo
  import r_forward_arbiter_pkg::*;
#(
  parameter int W = 2,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic         full_o
);
  localparam int AW = clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d;
  logic valid_q, valid_d, empty, do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign head_o = head_q;
  assign valid_o = valid_q;
  // next pointers/count; a push into an otherwise-empty FIFO becomes the head directly
  always_comb begin
    do_push = push_i & ~full_o;
    do_pop = pop_i & ~empty;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    valid_d = cnt_d != '0;
    head_d = !valid_d ? '0 : (do_push && cnt_q == (AW+1)'(do_pop)) ? din_i : mem_q[rd_d];
  end
  // pointer, count and registered head state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      head_q <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      head_q <= head_d;
      valid_q <= valid_d;
    end
  end
  // storage needs no reset; only entries below count are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/r_forward_arbiter.sv
// r_forward_arbiter: round-robin arbiter onto one forward channel with grant-order log
module r_forward_arbiter
  import r_forward_arbiter_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int ORDER_DEPTH = 8,
  parameter int ID_W = clog2(N_PORTS)
) (
  input logic CLK,
  input logic RST,
  r_forward_arbiter_if.slave bus
);
  state_t state_q;
  logic [ID_W-1:0] gnt_q, rr_q, pick;
  logic found, full, push, busy;
  assign busy = state_q == BUSY;
  // first valid requester at or above rr, wrapping; lowest offset wins
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (bus.VALIDi[(int'(rr_q) + i) % N_PORTS]) begin
        pick = ID_W'((int'(rr_q) + i) % N_PORTS);
        found = 1'b1;
      end
    end
  end
  // unregistered forward mux driven by the held grant
  always_comb begin
    bus.VALIDo = busy & bus.VALIDi[gnt_q];
    bus.DATAo = busy ? bus.DATAi[DATA_W*int'(gnt_q) +: DATA_W] : '0;
    bus.READYi = busy ? N_PORTS'(bus.READYo) << gnt_q : '0;
    push = bus.VALIDo & bus.READYo;
  end
  // grant FSM: capacity is checked only at grant so the later push always fits
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rr_q <= '0;
    end else if (!busy) begin
      if (found && !full) begin
        gnt_q <= pick;
        rr_q <= (int'(pick) == N_PORTS - 1) ? '0 : pick + 1'b1;
        state_q <= BUSY;
      end
    end else if (push) begin
      state_q <= IDLE;
    end
  end
  r_order_fifo #(.W(ID_W), .DEPTH(ORDER_DEPTH)) u_order_fifo (
    .clk(CLK),
    .rst(RST),
    .push_i(push),
    .din_i(gnt_q),
    .pop_i(bus.ORDER_POP),
    .head_o(bus.ORDER_ID),
    .valid_o(bus.ORDER_VALID),
    .full_o(full)
  );
endmodule

// File: tb/tb_r_forward_arbiter.sv
// tb_r_forward_arbiter: table vectors plus directed multi-cycle sequences
module tb_r_forward_arbiter;
  import r_forward_arbiter_pkg::*;
  localparam int N = 4;
  localparam int D = 8;
  localparam int IW = 2;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  r_forward_arbiter_if #(.N_PORTS(N), .ID_W(IW)) bus();
  r_forward_arbiter #(.N_PORTS(N), .ORDER_DEPTH(D), .ID_W(IW)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    logic [3:0] vld;
    logic rdy;
    logic pop;
    logic evo;
    logic [3:0] eri;
    int edp;
    logic eov;
    logic [1:0] eid;
  } vec_t;
  vec_t tbl [18];
  function automatic logic [DATA_W-1:0] dpat(input int k);
    return {8'(8'hA0 + k), 36'h0_1000_0000, 33'(k * 17 + 5) | 33'h1_0000_0000};
  endfunction
  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction
  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask
  task automatic xfer(input int port, input logic pop);
    bus.VALIDi = 4'(1 << port);
    bus.READYo = 1'b1;
    nxt();
    bus.ORDER_POP = pop;
    @(negedge CLK);
    chk("xfer_hs_ready", 77'(bus.READYi), 77'(1 << port));
    chk("xfer_hs_valid", 77'(bus.VALIDo), 77'(1));
    nxt();
    bus.VALIDi = '0;
    bus.ORDER_POP = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int ng, last, p;
    bit seen;
    tbl[0]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, -1, 1'b0, 2'd0};
    tbl[1]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100,  2, 1'b0, 2'd0};
    tbl[2]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, -1, 1'b1, 2'd2};
    tbl[3]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, -1, 1'b1, 2'd2};
    tbl[4]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, -1, 1'b0, 2'd0};
    tbl[5]  = '{4'b1001, 1'b1, 1'b0, 1'b0, 4'b0000, -1, 1'b0, 2'd0};
    tbl[6]  = '{4'b1001, 1'b1, 1'b0, 1'b1, 4'b1000,  3, 1'b0, 2'd0};
    tbl[7]  = '{4'b1001, 1'b1, 1'b0, 1'b0, 4'b0000, -1, 1'b1, 2'd3};
    tbl[8]  = '{4'b1001, 1'b1, 1'b0, 1'b1, 4'b0001,  0, 1'b1, 2'd3};
    tbl[9]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, -1, 1'b1, 2'd3};
    tbl[10] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, -1, 1'b1, 2'd0};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, -1, 1'b0, 2'd0};
    tbl[12] = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, -1, 1'b0, 2'd0};
    tbl[13] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0010,  1, 1'b0, 2'd0};
    tbl[14] = '{4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010,  1, 1'b0, 2'd0};
    tbl[15] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, -1, 1'b1, 2'd1};
    tbl[16] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, -1, 1'b1, 2'd1};
    tbl[17] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, -1, 1'b0, 2'd0};
    for (int k = 0; k < N; k++) bus.DATAi[k*DATA_W +: DATA_W] = dpat(k);
    bus.VALIDi = 4'b1111;
    bus.READYo = 1'b1;
    bus.ORDER_POP = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_valido", 77'(bus.VALIDo), 77'(0));
    chk("rst_readyi", 77'(bus.READYi), 77'(0));
    chk("rst_datao", bus.DATAo, '0);
    chk("rst_order_valid", 77'(bus.ORDER_VALID), 77'(0));
    chk("rst_order_id", 77'(bus.ORDER_ID), 77'(0));
    nxt();
    RST = 1'b0;
    for (int i = 0; i < 18; i++) begin
      bus.VALIDi = tbl[i].vld;
      bus.READYo = tbl[i].rdy;
      bus.ORDER_POP = tbl[i].pop;
      @(negedge CLK);
      chk($sformatf("vec%0d_valido", i), 77'(bus.VALIDo), 77'(tbl[i].evo));
      chk($sformatf("vec%0d_readyi", i), 77'(bus.READYi), 77'(tbl[i].eri));
      chk($sformatf("vec%0d_datao", i), bus.DATAo, tbl[i].edp < 0 ? '0 : dpat(tbl[i].edp));
      chk($sformatf("vec%0d_order_valid", i), 77'(bus.ORDER_VALID), 77'(tbl[i].eov));
      chk($sformatf("vec%0d_order_id", i), 77'(bus.ORDER_ID), 77'(tbl[i].eid));
      nxt();
    end
    bus.ORDER_POP = 1'b0;
    RST = 1'b1;
    nxt();
    RST = 1'b0;
    bus.VALIDi = 4'b1111;
    bus.READYo = 1'b1;
    ng = 0;
    last = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (bus.VALIDo && bus.READYo) begin
        chk("rr_order", 77'(oh_idx(bus.READYi)), 77'(ng % 4));
        if (ng > 0) chk("rr_spacing", 77'(c - last), 77'(2));
        last = c;
        ng++;
      end
      if (c >= 16) chk("full_stall_valido", 77'(bus.VALIDo), 77'(0));
      nxt();
    end
    chk("rr_grant_count", 77'(ng), 77'(8));
    bus.ORDER_POP = 1'b1;
    @(negedge CLK);
    chk("full_head_id", 77'(bus.ORDER_ID), 77'(0));
    nxt();
    bus.ORDER_POP = 1'b0;
    seen = 0;
    p = -1;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge CLK);
      if (bus.VALIDo && bus.READYo) begin
        seen = 1;
        p = oh_idx(bus.READYi);
      end
      nxt();
    end
    bus.VALIDi = '0;
    chk("after_pop_grant_seen", 77'(seen), 77'(1));
    chk("after_pop_grant_port", 77'(p), 77'(0));
    for (int i = 0; i < 8; i++) begin
      bus.ORDER_POP = 1'b1;
      @(negedge CLK);
      chk("drain_valid", 77'(bus.ORDER_VALID), 77'(1));
      chk($sformatf("drain_id%0d", i), 77'(bus.ORDER_ID), 77'((i + 1) % 4));
      nxt();
    end
    bus.ORDER_POP = 1'b0;
    @(negedge CLK);
    chk("drain_empty", 77'(bus.ORDER_VALID), 77'(0));
    nxt();
    bus.VALIDi = 4'b1010;
    bus.READYo = 1'b0;
    nxt();
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("bp_valido", 77'(bus.VALIDo), 77'(1));
      chk("bp_readyi", 77'(bus.READYi), 77'(0));
      chk("bp_datao", bus.DATAo, dpat(1));
      nxt();
    end
    bus.READYo = 1'b1;
    @(negedge CLK);
    chk("bp_release_readyi", 77'(bus.READYi), 77'(4'b0010));
    nxt();
    @(negedge CLK);
    chk("bp_idle_valido", 77'(bus.VALIDo), 77'(0));
    nxt();
    @(negedge CLK);
    chk("bp_next_readyi", 77'(bus.READYi), 77'(4'b1000));
    chk("bp_next_datao", bus.DATAo, dpat(3));
    nxt();
    bus.VALIDi = '0;
    xfer(2, 1'b0);
    xfer(0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.ORDER_POP = 1'b1;
      @(negedge CLK);
      chk("pp_valid", 77'(bus.ORDER_VALID), 77'(1));
      chk($sformatf("pp_id%0d", i), 77'(bus.ORDER_ID), 77'(i == 0 ? 3 : i == 1 ? 2 : 0));
      nxt();
    end
    bus.ORDER_POP = 1'b0;
    @(negedge CLK);
    chk("pp_count_empty", 77'(bus.ORDER_VALID), 77'(0));
    nxt();
    xfer(1, 1'b0);
    bus.VALIDi = 4'b0100;
    bus.READYo = 1'b0;
    nxt();
    @(negedge CLK);
    chk("rb_busy_valido", 77'(bus.VALIDo), 77'(1));
    chk("rb_fifo_valid", 77'(bus.ORDER_VALID), 77'(1));
    nxt();
    RST = 1'b1;
    nxt();
    RST = 1'b0;
    bus.VALIDi = 4'b0010;
    bus.READYo = 1'b1;
    @(negedge CLK);
    chk("rb_valido", 77'(bus.VALIDo), 77'(0));
    chk("rb_readyi", 77'(bus.READYi), 77'(0));
    chk("rb_order_valid", 77'(bus.ORDER_VALID), 77'(0));
    nxt();
    @(negedge CLK);
    chk("rb_regrant_readyi", 77'(bus.READYi), 77'(4'b0010));
    chk("rb_regrant_valido", 77'(bus.VALIDo), 77'(1));
    nxt();
    bus.VALIDi = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
